// File: rtl/key_encoder_if.sv
// Keypad-to-display bundle: raw key lines toward the encoder, BCD code and latch strobe back out.
interface key_encoder_if;
    logic [9:0] key;
    logic       S0;
    logic       S1;
    logic       S2;
    logic       S3;
    logic       ready;

    // The keypad/display side drives key and observes the code.
    modport master (
        output key,
        input  S0, S1, S2, S3, ready
    );

    // The encoder samples key and drives the code.
    modport slave (
        input  key,
        output S0, S1, S2, S3, ready
    );
endinterface

// File: rtl/key_encoder.sv
// Synchronises and debounces ten decimal keypad lines and emits one BCD code plus a
// single-cycle ready strobe per accepted keypress.
module key_encoder #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    key_encoder_if.slave bus
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [9:0]       ONE10   = 10'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_LATCH,
        S_FIRE,
        S_RELEASE
    } state_t;

    logic [9:0]       r_sync_p0;
    logic [9:0]       r_sync_p1;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_cand;
    logic [3:0]       r_code;
    logic             r_ready;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [3:0]       w_cand_nxt;
    logic [3:0]       w_code_nxt;
    logic             w_load;
    logic [9:0]       w_ks;
    logic             w_onehot;
    logic             w_is_cand;
    logic [3:0]       w_enc;

    assign w_ks      = r_sync_p1;
    assign w_onehot  = (w_ks != '0) && ((w_ks & (w_ks - 10'd1)) == '0);
    assign w_is_cand = (w_ks == (ONE10 << r_cand));
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_enc = '0;
        for (int i = 0; i < 10; i++) begin
            if (w_ks[i]) w_enc = 4'(i);
        end
    end

    // The code register loads on entry to LATCH so S0..S3 settle a full cycle before ready.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_code_nxt  = r_cand;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_onehot) begin
                    w_cand_nxt = w_enc;
                    w_cnt_nxt  = CNT_ONE;
                    if (CNT_ONE == CNT_MAX) begin
                        w_state_nxt = S_LATCH;
                        w_code_nxt  = w_enc;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = S_DEBOUNCE;
                    end
                end
            end
            S_DEBOUNCE: begin
                if (w_is_cand) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == CNT_MAX) begin
                        w_state_nxt = S_LATCH;
                        w_load      = 1'b1;
                    end
                end else begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            S_LATCH: begin
                w_state_nxt = S_FIRE;
            end
            S_FIRE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                if (w_ks == '0) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == CNT_MAX) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Stage p0/p1: two-flop synchroniser; FSM state, counter and registered outputs follow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_cand    <= '0;
            r_code    <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_sync_p0 <= bus.key;
            r_sync_p1 <= r_sync_p0;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cand    <= w_cand_nxt;
            if (w_load) r_code <= w_code_nxt;
            r_ready   <= (w_state_nxt == S_FIRE);
        end
    end

    assign bus.S0    = r_code[3];
    assign bus.S1    = r_code[2];
    assign bus.S2    = r_code[1];
    assign bus.S3    = r_code[0];
    assign bus.ready = r_ready;

endmodule

// File: tb/tb_key_encoder.sv
// Bench for key_encoder: a DEBOUNCE_CYCLES=4 unit driven from a segment table with a strobe
// scoreboard, plus a DEBOUNCE_CYCLES=1 unit for the single-cycle debounce boundary.
module tb_key_encoder;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    key_encoder_if bus0 ();
    key_encoder_if bus1 ();

    key_encoder #(.DEBOUNCE_CYCLES(4)) u_dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    key_encoder #(.DEBOUNCE_CYCLES(1)) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    int errors = 0;
    int checks = 0;
    int n_str0 = 0;
    int n_str1 = 0;
    int exp_total = 0;
    logic [3:0] exp_q[$];
    logic [3:0] prev0 = '0;
    logic [3:0] code0;
    logic [3:0] code1;

    assign code0 = {bus0.S0, bus0.S1, bus0.S2, bus0.S3};
    assign code1 = {bus1.S0, bus1.S1, bus1.S2, bus1.S3};

    typedef struct packed {
        logic [9:0] key;
        int         hold;
        int         n_str;
        logic [3:0] exp_s;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each strobe must match the next queued code, and the code must already
    // have been stable at the previous sample.
    always @(negedge clk) begin
        if (bus0.ready) begin
            n_str0++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected code=%b required=no_strobe at %0t", code0, $time);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (code0 !== e) begin
                    errors++;
                    $display("FAIL strobe_code actual=%b required=%b at %0t", code0, e, $time);
                end
            end
            checks++;
            if (code0 !== prev0) begin
                errors++;
                $display("FAIL code_setup actual_prev=%b required=%b at %0t", prev0, code0, $time);
            end
        end
        if (bus1.ready) n_str1++;
        prev0 = code0;
    end

    initial begin
        tbl[0]  = '{10'h000, 10, 0, 4'b0111};
        tbl[1]  = '{10'h008,  3, 0, 4'b0111};
        tbl[2]  = '{10'h000,  1, 0, 4'b0111};
        tbl[3]  = '{10'h008, 10, 1, 4'b0011};
        tbl[4]  = '{10'h000, 10, 0, 4'b0011};
        tbl[5]  = '{10'h024, 20, 0, 4'b0011};
        tbl[6]  = '{10'h000, 10, 0, 4'b0011};
        tbl[7]  = '{10'h200, 10, 1, 4'b1001};
        tbl[8]  = '{10'h202, 10, 0, 4'b1001};
        tbl[9]  = '{10'h000, 10, 0, 4'b1001};
        tbl[10] = '{10'h002, 10, 1, 4'b0001};
        tbl[11] = '{10'h000, 10, 0, 4'b0001};
        tbl[12] = '{10'h010, 10, 1, 4'b0100};
        tbl[13] = '{10'h000,  2, 0, 4'b0100};
        tbl[14] = '{10'h010, 10, 0, 4'b0100};
        tbl[15] = '{10'h000,  6, 0, 4'b0100};
        tbl[16] = '{10'h010, 10, 1, 4'b0100};

        reset_n   = 1'b0;
        bus0.key  = '0;
        bus1.key  = '0;
        #12;
        chk("rst_code0", 32'(code0), 32'h0);
        chk("rst_ready0", 32'(bus0.ready), 32'h0);
        chk("rst_code1", 32'(code1), 32'h0);
        chk("rst_ready1", 32'(bus1.ready), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) step();

        // key[7]: code at edge 6, ready only between edges 7 and 8.
        exp_q.push_back(4'b0111);
        exp_total++;
        bus0.key = 10'h080;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("lat_code_e%0d", k), 32'(code0), (k >= 6) ? 32'h7 : 32'h0);
            chk($sformatf("lat_ready_e%0d", k), 32'(bus0.ready), (k == 7) ? 32'h1 : 32'h0);
        end
        repeat (8) step();

        for (int v = 0; v < 17; v++) begin
            for (int s = 0; s < tbl[v].n_str; s++) exp_q.push_back(tbl[v].exp_s);
            exp_total += tbl[v].n_str;
            bus0.key = tbl[v].key;
            repeat (tbl[v].hold) step();
            chk($sformatf("vec%0d_code", v), 32'(code0), 32'(tbl[v].exp_s));
            chk($sformatf("vec%0d_pending", v), 32'(exp_q.size()), 32'h0);
        end
        bus0.key = '0;
        repeat (10) step();
        chk("strobe_total", 32'(n_str0), 32'(exp_total));

        // key[6] with reset pulsed during the FIRE cycle.
        bus0.key = 10'h040;
        repeat (7) step();
        chk("fire_ready_pre", 32'(bus0.ready), 32'h1);
        chk("fire_code_pre", 32'(code0), 32'h6);
        #1;
        reset_n  = 1'b0;
        bus0.key = '0;
        #1;
        chk("fire_ready_rst", 32'(bus0.ready), 32'h0);
        chk("fire_code_rst", 32'(code0), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) step();
        chk("post_rst_code", 32'(code0), 32'h0);
        chk("post_rst_strobes", 32'(n_str0), 32'(exp_total));
        exp_q.push_back(4'b0110);
        exp_total++;
        bus0.key = 10'h040;
        repeat (10) step();
        bus0.key = '0;
        repeat (10) step();
        chk("fresh_code", 32'(code0), 32'h6);
        chk("fresh_strobes", 32'(n_str0), 32'(exp_total));

        // Single-cycle debounce: code at edge 3, ready at edge 4.
        bus1.key = 10'h020;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("n1_code_e%0d", k), 32'(code1), (k >= 3) ? 32'h5 : 32'h0);
            chk($sformatf("n1_ready_e%0d", k), 32'(bus1.ready), (k == 4) ? 32'h1 : 32'h0);
        end
        repeat (10) step();
        chk("n1_held_strobes", 32'(n_str1), 32'h1);
        bus1.key = '0;
        repeat (5) step();
        bus1.key = 10'h100;
        repeat (6) step();
        bus1.key = '0;
        chk("n1_code2", 32'(code1), 32'h8);
        chk("n1_strobes2", 32'(n_str1), 32'h2);

        repeat (5) step();
        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
